// File: rtl/libc_hdl_pkg.sv
// Types and defaults shared by the libc_hdl memory engines (memcpy/memcmp).
package libc_hdl_pkg;
  localparam int ADDR_WITH = 8;
  localparam int DATA_WITH = 8;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, FIN} state_e;

  typedef logic signed [DATA_WITH:0] diff_t;
endpackage

// File: rtl/memcmp_engine_if.sv
// Request/response and RAM read-port bundle of the memcmp engine.
interface memcmp_engine_if #(
  parameter int DATA_WITH = 8,
  parameter int ADDR_WITH = 8,
  parameter int NUM_WITH  = 8
) ();
  logic                        start;
  logic [ADDR_WITH-1:0]        s1;
  logic [ADDR_WITH-1:0]        s2;
  logic [NUM_WITH-1:0]         num;
  logic                        busy;
  logic                        done;
  logic signed [DATA_WITH:0]   diff;
  logic [NUM_WITH-1:0]         mis_idx;
  logic [ADDR_WITH-1:0]        mem_addr;
  logic                        mem_oe;
  logic                        mem_we;
  logic [DATA_WITH-1:0]        mem_rd_q;

  modport slave (
    input  start, s1, s2, num, mem_rd_q,
    output busy, done, diff, mis_idx, mem_addr, mem_oe, mem_we
  );

  modport master (
    output start, s1, s2, num, mem_rd_q,
    input  busy, done, diff, mis_idx, mem_addr, mem_oe, mem_we
  );
endinterface

// File: rtl/memcmp_addr_gen.sv
// Index counter, region base registers and A/B address mux for memcmp.
module memcmp_addr_gen #(
  parameter int ADDR_WITH = 8,
  parameter int NUM_WITH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_inc,
  input  logic                 i_sel_b,
  input  logic [ADDR_WITH-1:0] i_s1,
  input  logic [ADDR_WITH-1:0] i_s2,
  input  logic [NUM_WITH-1:0]  i_num,
  output logic [ADDR_WITH-1:0] o_addr,
  output logic [NUM_WITH-1:0]  o_idx,
  output logic [NUM_WITH-1:0]  o_num,
  output logic                 o_last
);
  logic [ADDR_WITH-1:0] r_base_a;
  logic [ADDR_WITH-1:0] r_base_b;
  logic [NUM_WITH-1:0]  r_num;
  logic [NUM_WITH-1:0]  r_idx;
  logic [NUM_WITH-1:0]  w_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base_a <= '0;
      r_base_b <= '0;
      r_num    <= '0;
      r_idx    <= '0;
    end else if (i_load) begin
      r_base_a <= i_s1;
      r_base_b <= i_s2;
      r_num    <= i_num;
      r_idx    <= '0;
    end else if (i_inc) begin
      r_idx    <= w_idx_nxt;
    end
  end

  assign w_idx_nxt = r_idx + NUM_WITH'(1);
  assign o_last    = (w_idx_nxt == r_num);
  // Addition wraps naturally at ADDR_WITH bits.
  assign o_addr    = (i_sel_b ? r_base_b : r_base_a) + ADDR_WITH'(r_idx);
  assign o_idx     = r_idx;
  assign o_num     = r_num;
endmodule

// File: rtl/memcmp_engine.sv
// Hardware memcmp: reads A[i], B[i] alternately and stops at the first differing byte.
module memcmp_engine #(
  parameter int DATA_WITH = libc_hdl_pkg::DATA_WITH,
  parameter int ADDR_WITH = libc_hdl_pkg::ADDR_WITH,
  parameter int NUM_WITH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  memcmp_engine_if.slave  bus
);
  import libc_hdl_pkg::*;

  state_e                    r_state;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_oe;
  logic [DATA_WITH-1:0]      r_byte_a;
  logic signed [DATA_WITH:0] r_diff;
  logic [NUM_WITH-1:0]       r_mis_idx;

  logic                      w_accept;
  logic                      w_mismatch;
  logic                      w_last;
  logic                      w_inc;
  logic [ADDR_WITH-1:0]      w_addr;
  logic [NUM_WITH-1:0]       w_idx;
  logic [NUM_WITH-1:0]       w_num;

  function automatic logic signed [DATA_WITH:0] byte_diff(
    input logic [DATA_WITH-1:0] a,
    input logic [DATA_WITH-1:0] b
  );
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_mismatch = (r_byte_a != bus.mem_rd_q);
  assign w_inc      = (r_state == CMP) && !w_mismatch && !w_last;

  memcmp_addr_gen #(
    .ADDR_WITH (ADDR_WITH),
    .NUM_WITH  (NUM_WITH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_inc   (w_inc),
    .i_sel_b (r_state == RD_B),
    .i_s1    (bus.s1),
    .i_s2    (bus.s2),
    .i_num   (bus.num),
    .o_addr  (w_addr),
    .o_idx   (w_idx),
    .o_num   (w_num),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_oe      <= 1'b0;
      r_diff    <= '0;
      r_mis_idx <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_diff    <= '0;
            r_mis_idx <= '0;
            if (bus.num == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_A;
              r_busy  <= 1'b1;
              r_oe    <= 1'b1;
            end
          end
        end
        RD_A: r_state <= RD_B;
        RD_B: begin
          r_state <= CMP;
          r_oe    <= 1'b0;
        end
        // B[i] arrives on the read port during CMP; A[i] was latched in RD_B.
        CMP: begin
          if (w_mismatch) begin
            r_diff    <= byte_diff(r_byte_a, bus.mem_rd_q);
            r_mis_idx <= w_idx;
            r_state   <= FIN;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_last) begin
            r_diff    <= '0;
            r_mis_idx <= w_num;
            r_state   <= FIN;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state <= RD_A;
            r_oe    <= 1'b1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == RD_B) r_byte_a <= bus.mem_rd_q;
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.diff     = r_diff;
  assign bus.mis_idx  = r_mis_idx;
  assign bus.mem_addr = w_addr;
  assign bus.mem_oe   = r_oe;
  assign bus.mem_we   = 1'b0;
endmodule

// File: tb/tb_memcmp_engine.sv
// Directed bench for memcmp_engine with a behavioural RAM and a result scoreboard.
module tb_memcmp_engine;
  import libc_hdl_pkg::*;

  typedef struct {
    int diff;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memcmp_engine_if b ();

  memcmp_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  logic [7:0] ram [256];
  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];
  logic [7:0] addr_log[$];

  // Synchronous read; 8'hEE stands in for the undriven bus when not reading.
  always @(posedge clk) b.mem_rd_q <= (b.mem_oe && !b.mem_we) ? ram[b.mem_addr] : 8'hEE;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b.mem_oe) addr_log.push_back(b.mem_addr);
    if (b.done) begin
      check("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_diff", b.diff, e.diff);
        check("sb_mis_idx", int'(b.mis_idx), e.idx);
      end
    end
  end

  function automatic void model(input int s1, input int s2, input int n,
                                output int d, output int idx, output int lat);
    d   = 0;
    idx = n;
    lat = 3 * n + 1;
    for (int i = 0; i < n; i++) begin
      int a;
      int bb;
      a  = int'(ram[(s1 + i) % 256]);
      bb = int'(ram[(s2 + i) % 256]);
      if (a != bb) begin
        d   = a - bb;
        idx = i;
        lat = 3 * (i + 1) + 1;
        break;
      end
    end
  endfunction

  task automatic push_exp(input int s1, input int s2, input int n, output int lat);
    int   d;
    int   idx;
    exp_t e;
    model(s1, s2, n, d, idx, lat);
    e.diff = d;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic start_req(input int s1, input int s2, input int n);
    @(negedge clk);
    b.start = 1'b1;
    b.s1    = 8'(s1);
    b.s2    = 8'(s2);
    b.num   = 8'(n);
    @(negedge clk);
    b.start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc, output int busy_cyc);
    cyc      = cyc0;
    busy_cyc = 0;
    while (b.done !== 1'b1 && cyc < 300) begin
      if (b.busy === 1'b1) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", int'(b.done), 1);
  endtask

  task automatic run(input string tag, input int s1, input int s2, input int n);
    int lat;
    int cyc;
    int busy_cyc;
    push_exp(s1, s2, n, lat);
    addr_log.delete();
    start_req(s1, s2, n);
    wait_done(1, cyc, busy_cyc);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busy_cycles"}, busy_cyc, lat - 1);
    check({tag, "_busy_at_done"}, int'(b.busy), 0);
  endtask

  initial begin
    int lat;
    int cyc;
    int busy_cyc;
    int dones;
    int wexp[8];

    rst     = 1'b1;
    b.start = 1'b0;
    b.s1    = '0;
    b.s2    = '0;
    b.num   = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(b.busy), 0);
    check("rst_done", int'(b.done), 0);
    check("rst_diff", b.diff, 0);
    check("rst_mis_idx", int'(b.mis_idx), 0);
    check("rst_oe", int'(b.mem_oe), 0);
    check("rst_addr", int'(b.mem_addr), 0);
    check("mem_we", int'(b.mem_we), 0);
    rst = 1'b0;

    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;
    ram[8'h20] = 8'h11; ram[8'h21] = 8'h22; ram[8'h22] = 8'h33; ram[8'h23] = 8'h44;
    run("match4", 16, 32, 4);
    check("match4_reads", addr_log.size(), 8);

    ram[8'h22] = 8'h30;
    run("mism", 16, 32, 4);
    check("mism_reads", addr_log.size(), 6);
    check("mism_last_addr", addr_log.size() > 0 ? int'(addr_log[$]) : -1, 8'h22);
    @(negedge clk);
    check("mism_diff_held", b.diff, 3);
    check("mism_idx_held", int'(b.mis_idx), 2);

    ram[8'h10] = 8'h01;
    ram[8'h20] = 8'hFF;
    run("neg", 16, 32, 1);
    @(negedge clk);
    check("neg_diff_bits", int'($unsigned(b.diff)), 9'h102);

    run("zero", 1, 2, 0);
    check("zero_reads", addr_log.size(), 0);

    ram[8'hFE] = 8'h05; ram[8'hFF] = 8'h06; ram[8'h00] = 8'h07; ram[8'h01] = 8'h08;
    ram[8'h7E] = 8'h05; ram[8'h7F] = 8'h06; ram[8'h80] = 8'h07; ram[8'h81] = 8'h08;
    wexp = '{254, 126, 255, 127, 0, 128, 1, 129};
    run("wrap", 254, 126, 4);
    check("wrap_reads", addr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("wrap_addr%0d", i), i < addr_log.size() ? int'(addr_log[i]) : -1, wexp[i]);

    // Abort during RD_B of byte 1 (cycle 5 after the start edge).
    ram[8'h10] = 8'h11; ram[8'h20] = 8'h11; ram[8'h22] = 8'h33;
    start_req(16, 32, 4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(b.busy), 0);
    check("abort_oe", int'(b.mem_oe), 0);
    check("abort_done", int'(b.done), 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (b.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run("after_rst", 16, 32, 2);

    // A start pulse while busy must be ignored.
    push_exp(16, 32, 4, lat);
    start_req(16, 32, 4);
    @(negedge clk);
    b.start = 1'b1;
    b.s1    = 8'h40;
    b.s2    = 8'h10;
    b.num   = 8'd1;
    @(negedge clk);
    b.start = 1'b0;
    wait_done(3, cyc, busy_cyc);
    check("ignore_latency", cyc, lat);
    repeat (12) @(negedge clk);
    check("ignore_busy_idle", int'(b.busy), 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
